// File: rtl/lcd_num_writer.sv
// Character-LCD number printer: power-on init of a 4-bit HD44780-style bus, then
// prints a sign and NDIGITS BCD digits at a fixed row/column on each start request.
module lcd_num_writer #(
  parameter int NDIGITS   = 2,
  parameter int ROW       = 0,
  parameter int START_COL = 0,
  parameter int CYC_PWR   = 750000,
  parameter int CYC_INIT1 = 205000,
  parameter int CYC_INIT2 = 5000,
  parameter int CYC_E     = 12,
  parameter int CYC_GAP   = 50,
  parameter int CYC_CMD   = 2000,
  parameter int CYC_CLR   = 82000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sign,
  input  logic [4*NDIGITS-1:0]   digits,
  input  logic                   leading_blank,
  output logic                   ready,
  output logic                   done,
  output logic                   sf_e,
  output logic                   e,
  output logic                   rs,
  output logic                   rw,
  output logic [3:0]             nibble
);

  localparam int CNT_W = $clog2(CYC_PWR + CYC_INIT1 + CYC_INIT2 + CYC_E + CYC_GAP
                                + CYC_CMD + CYC_CLR + 2);
  localparam logic [7:0] CMD_POS = 8'(128 + ROW * 64 + START_COL);

  typedef enum logic [2:0] {
    S_PWR, S_SETUP, S_EHI, S_HOLD, S_GAP, S_WAIT, S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    P_INIT, P_CFG, P_PRINT
  } phase_t;

  state_t               r_state;
  phase_t               r_phase;
  logic [3:0]           r_idx;
  logic                 r_low;
  logic                 r_fin;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign;
  logic [4*NDIGITS-1:0] r_digits;
  logic                 r_blank;
  logic                 r_e;
  logic                 r_rs;
  logic [3:0]           r_nibble;
  logic                 r_ready;
  logic                 r_done;

  logic [3:0]           w_dig   [NDIGITS];
  logic                 w_zrun  [NDIGITS];
  logic [7:0]           w_chars [NDIGITS];
  logic [7:0]           w_byte;
  logic                 w_rs;
  logic [CNT_W-1:0]     w_wait;

  // Leftmost digit first; a run of zeros from the left is blanked except the last digit.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_dig
      assign w_dig[gi] = r_digits[4*(NDIGITS-gi)-1 -: 4];
      if (gi == 0) begin : g_first
        assign w_zrun[gi] = r_blank & (w_dig[gi] == 4'd0);
      end else begin : g_next
        assign w_zrun[gi] = w_zrun[gi-1] & (w_dig[gi] == 4'd0);
      end
      if (gi == NDIGITS - 1) begin : g_last
        assign w_chars[gi] = (w_dig[gi] > 4'd9) ? 8'h3F : {4'h3, w_dig[gi]};
      end else begin : g_lead
        assign w_chars[gi] = (w_dig[gi] > 4'd9) ? 8'h3F :
                             w_zrun[gi]         ? 8'h20 : {4'h3, w_dig[gi]};
      end
    end
  endgenerate

  // Byte (or init nibble) addressed by the current phase/index.
  always_comb begin
    w_byte = 8'h00;
    case (r_phase)
      P_INIT: w_byte = (r_idx == 4'd3) ? 8'h02 : 8'h03;
      P_CFG: begin
        case (r_idx)
          4'd0:    w_byte = 8'h28;
          4'd1:    w_byte = 8'h06;
          4'd2:    w_byte = 8'h0C;
          default: w_byte = 8'h01;
        endcase
      end
      default: begin
        if (r_idx == 4'd0) begin
          w_byte = CMD_POS;
        end else if (r_idx == 4'd1) begin
          w_byte = r_sign ? 8'h2D : 8'h20;
        end else begin
          for (int k = 0; k < NDIGITS; k++) begin
            if (r_idx == 4'(k + 2)) w_byte = w_chars[k];
          end
        end
      end
    endcase
  end

  assign w_rs = (r_phase == P_PRINT) && (r_idx != 4'd0);

  always_comb begin
    w_wait = CNT_W'(CYC_CMD - 1);
    if (r_phase == P_INIT) begin
      if (r_idx == 4'd0)      w_wait = CNT_W'(CYC_INIT1 - 1);
      else if (r_idx == 4'd1) w_wait = CNT_W'(CYC_INIT2 - 1);
    end else if (w_byte == 8'h01) begin
      w_wait = CNT_W'(CYC_CLR - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_PWR;
      r_phase  <= P_INIT;
      r_idx    <= '0;
      r_low    <= 1'b0;
      r_fin    <= 1'b0;
      r_cnt    <= CNT_W'(CYC_PWR - 1);
      r_sign   <= 1'b0;
      r_digits <= '0;
      r_blank  <= 1'b0;
      r_e      <= 1'b0;
      r_rs     <= 1'b0;
      r_nibble <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_PWR: begin
          if (r_cnt == '0) begin
            r_state  <= S_SETUP;
            r_nibble <= 4'h3;
            r_rs     <= 1'b0;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_EHI;
            r_e     <= 1'b1;
            r_cnt   <= CNT_W'(CYC_E - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_EHI: begin
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_e     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_phase != P_INIT && !r_low) begin
            r_state <= S_GAP;
            r_low   <= 1'b1;
            r_cnt   <= CNT_W'(CYC_GAP - 1);
          end else begin
            // Step the index now so the next byte is ready when the wait expires.
            r_state <= S_WAIT;
            r_low   <= 1'b0;
            r_cnt   <= w_wait;
            case (r_phase)
              P_INIT: begin
                if (r_idx == 4'd3) begin
                  r_phase <= P_CFG;
                  r_idx   <= '0;
                end else begin
                  r_idx <= r_idx + 4'd1;
                end
              end
              P_CFG: begin
                if (r_idx == 4'd3) r_fin <= 1'b1;
                else               r_idx <= r_idx + 4'd1;
              end
              default: begin
                if (r_idx == 4'(NDIGITS + 1)) r_fin <= 1'b1;
                else                          r_idx <= r_idx + 4'd1;
              end
            endcase
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state  <= S_SETUP;
            r_nibble <= w_byte[3:0];
            r_cnt    <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_fin) begin
              r_state <= S_IDLE;
              r_fin   <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= (r_phase == P_PRINT);
            end else begin
              r_state  <= S_SETUP;
              r_nibble <= (r_phase == P_INIT) ? w_byte[3:0] : w_byte[7:4];
              r_rs     <= w_rs;
              r_cnt    <= CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            r_sign   <= sign;
            r_digits <= digits;
            r_blank  <= leading_blank;
            r_ready  <= 1'b0;
            r_phase  <= P_PRINT;
            r_idx    <= '0;
            r_low    <= 1'b0;
            r_fin    <= 1'b0;
            r_state  <= S_SETUP;
            r_nibble <= CMD_POS[7:4];
            r_rs     <= 1'b0;
            r_cnt    <= CNT_W'(1);
          end
        end
        default: r_state <= S_PWR;
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign sf_e   = 1'b1;
  assign e      = r_e;
  assign rs     = r_rs;
  assign rw     = 1'b0;
  assign nibble = r_nibble;

endmodule
